// File: rtl/mux32_16x1.sv
// Wide 16:1 word selector built as a binary tree of 2:1 stages, plus a
// registered copy of the selected word for pipelined consumers.

module mux32_16x1_mux2 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  sel,
  output logic [DATA_WIDTH-1:0] y
);
  // An unknown select merges both legs, so no single unselected word leaks out.
  assign y = sel ? b : a;
endmodule

module mux32_16x1 #(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4
) (
  output logic [DATA_WIDTH-1:0] Y,
  input  logic [DATA_WIDTH-1:0] I0,
  input  logic [DATA_WIDTH-1:0] I1,
  input  logic [DATA_WIDTH-1:0] I2,
  input  logic [DATA_WIDTH-1:0] I3,
  input  logic [DATA_WIDTH-1:0] I4,
  input  logic [DATA_WIDTH-1:0] I5,
  input  logic [DATA_WIDTH-1:0] I6,
  input  logic [DATA_WIDTH-1:0] I7,
  input  logic [DATA_WIDTH-1:0] I8,
  input  logic [DATA_WIDTH-1:0] I9,
  input  logic [DATA_WIDTH-1:0] I10,
  input  logic [DATA_WIDTH-1:0] I11,
  input  logic [DATA_WIDTH-1:0] I12,
  input  logic [DATA_WIDTH-1:0] I13,
  input  logic [DATA_WIDTH-1:0] I14,
  input  logic [DATA_WIDTH-1:0] I15,
  input  logic [SEL_WIDTH-1:0]  S,
  input  logic                  CLK,
  input  logic                  RST,
  output logic [DATA_WIDTH-1:0] Y_REG
);
  localparam int NUM_IN = 1 << SEL_WIDTH;
  localparam int NUM_NODES = 2 * NUM_IN - 1;

  logic [15:0][DATA_WIDTH-1:0]           din;
  logic [NUM_NODES-1:0][DATA_WIDTH-1:0]  node;
  logic [DATA_WIDTH-1:0]                 y_reg_d, y_reg_q;

  assign din = {I15, I14, I13, I12, I11, I10, I9, I8,
                I7,  I6,  I5,  I4,  I3,  I2,  I1, I0};

  // Heap layout: node k has children 2k+1 (sel=0) and 2k+2 (sel=1);
  // leaves sit left to right as I0..I15, so depth d is steered by S[SEL_WIDTH-1-d].
  genvar gi, gd, gj;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_leaf
      assign node[NUM_IN-1+gi] = din[gi];
    end
    for (gd = 0; gd < SEL_WIDTH; gd++) begin : g_lvl
      for (gj = 0; gj < (1 << gd); gj++) begin : g_stage
        localparam int K = (1 << gd) - 1 + gj;
        mux32_16x1_mux2 #(.DATA_WIDTH(DATA_WIDTH)) u_mux2 (
          .a   (node[2*K+1]),
          .b   (node[2*K+2]),
          .sel (S[SEL_WIDTH-1-gd]),
          .y   (node[K])
        );
      end
    end
  endgenerate

  assign Y = node[0];

  always_comb begin
    y_reg_d = Y;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) y_reg_q <= '0;
    else     y_reg_q <= y_reg_d;
  end

  assign Y_REG = y_reg_q;
endmodule

// File: tb/tb_mux32_16x1.sv
// Scoreboard bench for mux32_16x1: expected words queued at drive time,
// popped and compared when the output is sampled.

module tb_mux32_16x1;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  s = '0;
  logic [31:0] in_w [16];
  logic [31:0] y, y_reg;
  logic [31:0] yq [$];
  logic [31:0] rq [$];
  int total = 0;
  int bad = 0;

  mux32_16x1 dut (
    .Y(y),
    .I0(in_w[0]),   .I1(in_w[1]),   .I2(in_w[2]),   .I3(in_w[3]),
    .I4(in_w[4]),   .I5(in_w[5]),   .I6(in_w[6]),   .I7(in_w[7]),
    .I8(in_w[8]),   .I9(in_w[9]),   .I10(in_w[10]), .I11(in_w[11]),
    .I12(in_w[12]), .I13(in_w[13]), .I14(in_w[14]), .I15(in_w[15]),
    .S(s), .CLK(clk), .RST(rst), .Y_REG(y_reg)
  );

  always #5 clk = ~clk;

  task automatic check_y(input string name);
    logic [31:0] exp;
    exp = yq.pop_front();
    total++;
    if (y !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, y, exp);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 16; i++) in_w[i] = 32'h0;
    rst = 1'b1;
    @(negedge clk);
    s = 4'd5; in_w[5] = 32'h5a5a_a5a5;
    yq.push_back(32'h5a5a_a5a5);
    #1;
    total++;
    if (y_reg !== 32'h0) begin
      bad++; $display("FAIL reset_yreg: got %h want 00000000", y_reg);
    end
    check_y("reset_y_live");
  endtask

  task automatic test_lower_sweep();
    logic [31:0] vals [8];
    vals = '{32'h00012340, 32'habc21000, 32'h00033300, 32'h00aadd00,
             32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777};
    for (int i = 0; i < 8; i++) in_w[i] = vals[i];
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s = 4'(i);
      yq.push_back(vals[i]);
      #1 check_y("lower_sweep");
    end
    @(negedge clk);
    s = 4'd1; in_w[1] = 32'hffffffff;
    yq.push_back(32'hffffffff);
    #1 check_y("lower_update");
  endtask

  task automatic test_upper_sweep();
    logic [31:0] vals [8];
    vals = '{32'h88888888, 32'h99999999, 32'haaaa1010, 32'hbbbb1111,
             32'hcccc1212, 32'hdddd1313, 32'heeee1414, 32'hffff1515};
    for (int i = 0; i < 8; i++) in_w[8+i] = vals[i];
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s = 4'(8 + i);
      yq.push_back(vals[i]);
      #1 check_y("upper_sweep");
    end
  endtask

  task automatic test_isolation();
    @(negedge clk);
    s = 4'd3; in_w[3] = 32'hacdefb00;
    for (int i = 0; i < 16; i++) begin
      if (i != 3) begin
        in_w[i] = 32'hffffffff;
        yq.push_back(32'hacdefb00);
        #1 check_y("isolation_set");
        in_w[i] = 32'h0;
        yq.push_back(32'hacdefb00);
        #1 check_y("isolation_clr");
      end
    end
  endtask

  task automatic test_input_change();
    @(negedge clk);
    s = 4'd2; in_w[2] = 32'h9999ffdd;
    yq.push_back(32'h9999ffdd);
    #1 check_y("chg_first");
    in_w[2] = 32'h0000ade0;
    yq.push_back(32'h0000ade0);
    #1 check_y("chg_second");
  endtask

  task automatic test_register();
    @(negedge clk);
    rst = 1'b0;
    s = 4'd15; in_w[15] = 32'hffff1515;
    rq.push_back(32'hffff1515);
    @(posedge clk); #1;
    total++;
    if (y_reg !== rq[0]) begin
      bad++; $display("FAIL reg_load: got %h want %h", y_reg, rq[0]);
    end
    void'(rq.pop_front());
    rst = 1'b1;
    yq.push_back(32'hffff1515);
    #1;
    total++;
    if (y_reg !== 32'h0) begin
      bad++; $display("FAIL reg_async_clear: got %h want 00000000", y_reg);
    end
    check_y("reg_y_during_rst");
    @(posedge clk); #1;
    total++;
    if (y_reg !== 32'h0) begin
      bad++; $display("FAIL reg_hold_in_rst: got %h want 00000000", y_reg);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] exp;
    int rbad;
    rbad = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      for (int i = 0; i < 16; i++) in_w[i] = $urandom;
      s = 4'($urandom_range(0, 15));
      exp = in_w[s];
      yq.push_back(exp);
      rq.push_back(exp);
      #1;
      exp = yq.pop_front();
      total++;
      if (y !== exp) begin
        bad++;
        if (rbad++ < 10) $display("FAIL rand_y: s=%0d got %h want %h", s, y, exp);
      end
      @(posedge clk); #1;
      exp = rq.pop_front();
      total++;
      if (y_reg !== exp) begin
        bad++;
        if (rbad++ < 10) $display("FAIL rand_yreg: got %h want %h", y_reg, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lower_sweep();
    test_upper_sweep();
    test_isolation();
    test_input_change();
    test_register();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux32_16x1.md
# mux32_16x1

32-bit, 16-input multiplexer: a 4-bit select `S` routes one of sixteen 32-bit data words to output `Y`. It is the wide selection primitive of the datapath, used wherever the register file, ALU or control unit must pick one of up to sixteen 32-bit sources. A registered copy of the selected word is also provided for pipelined consumers.

## Interface
Parameters:
- `DATA_WIDTH`, default 32 (`DATA_INDEX_LIMIT`+1): width of every data input and output.
- `SEL_WIDTH`, default 4: select width; input count is 2^`SEL_WIDTH` = 16.

Ports:
- `CLK`  input  1  single clock; rising edge active.
- `RST`  input  1  reset, asynchronous, active-high.
- `Y`  output  32  combinational selected word.
- `I0` … `I15`  input  32 each  data inputs, positional order I0..I15 after `Y`.
- `S`  input  4  select; value n routes `In`.
- `Y_REG`  output  32  registered copy of `Y`.

Port order: `Y, I0..I15, S, CLK, RST, Y_REG`. Positional instantiation using only the first 18 ports (`Y, I0..I15, S`) must remain legal; `CLK`/`RST` then float and only `Y_REG` is affected.

## Operation
- `Y = I[S]` for all 16 values of `S`; pure combinational, no latches, no enable.
- Decode is binary: `S[3]` selects the upper half (I8..I15) vs the lower half (I0..I7), `S[2:0]` selects within the half. A tree of 2:1 selection stages (15 stages of 32-bit 2:1 mux, 4 levels) is the required structure; behaviour must match the flat selection exactly.
- All 32 bits select independently and identically; no bit reordering, sign handling or masking.
- `S` containing X/Z: `Y` is don't-care (X acceptable); no output may be driven by an unselected input in that case once `S` resolves.
- Changes on unselected inputs must not disturb `Y`.
- `Y_REG`: on each rising `CLK`, load current `Y`. While `RST`=1, `Y_REG`=32'h00000000 regardless of `CLK`.
- `Y` does not depend on `RST` or `CLK`; it stays live during reset.

## Timing
- `Y`: zero-cycle latency; settles within the same delta/combinational path after any change on `S` or the selected input.
- `Y_REG`: one-cycle latency; reflects `Y` sampled at the most recent rising `CLK`.
- Reset assertion clears `Y_REG` immediately (asynchronous); deassertion is synchronized by the user; first load occurs at the first rising `CLK` with `RST`=0.
- `RST` and rising `CLK` simultaneous: reset wins, `Y_REG`=0.
- Reset value of every output: `Y_REG`=0; `Y` has no reset value (follows inputs).

## Test plan
- Lower half sweep: I0=00012340, I1=abc21000, I2=00033300, I3=00aadd00, I4..I7=44444444..77777777; S=0..7 -> Y=00012340, abc21000, 00033300, 00aadd00, 44444444, 55555555, 66666666, 77777777 respectively (with I0..I3 updated per step, Y tracks the new selected value, e.g. S=1 with I1=ffffffff -> Y=ffffffff).
- Upper half sweep: I8=88888888, I9=99999999, I10=aaaa1010, I11=bbbb1111, I12=cccc1212, I13=dddd1313, I14=eeee1414, I15=ffff1515; S=8..15 -> Y equals each in order.
- Isolation: S=3, I3=acdefb00 held, toggle every other input to ffffffff -> Y stays acdefb00.
- Same-time input change: S=2 fixed, I2 changes 9999ffdd -> 0000ade0 -> Y follows with no clock.
- Register/reset: RST=1 -> Y_REG=0 immediately without a clock edge; release RST, S=15, I15=ffff1515, one rising CLK -> Y_REG=ffff1515; assert RST mid-stream -> Y_REG=0 at once while Y still ffff1515.
- Exhaustive random: 1000 random (S, I0..I15) vectors -> Y==I[S] every vector, Y_REG equals previous-cycle Y.
